// File: rtl/chol_pkg.sv
// ---------------------------------------------------------------------------
// chol_pkg
// Shared constants for the Cholesky square-root result path.
//   CHOL_SQRT_LATENCY : square-root core latency in clken-qualified cycles
//   CHOL_SQRT_DW      : width of the square-root core result bus
//   CHOL_OUT_W        : width of the downstream result bus (zero-extended)
//   CHOL_FIFO_DEPTH   : default number of result buffer entries / credits
//   CHOL_OCC_W        : width of the occupancy (credit) counter
// ---------------------------------------------------------------------------
package chol_pkg;

    localparam int unsigned CHOL_SQRT_LATENCY = 14;
    localparam int unsigned CHOL_SQRT_DW      = 24;
    localparam int unsigned CHOL_OUT_W        = 32;
    localparam int unsigned CHOL_FIFO_DEPTH   = 4;
    localparam int unsigned CHOL_OCC_W        = 5;

endpackage

// File: rtl/chol_fifo.sv
// ---------------------------------------------------------------------------
// chol_fifo
// Synchronous FIFO holding square-root results until downstream takes them.
// The upstream credit scheme guarantees that no push arrives while the FIFO
// is full unless a pop happens on the same edge, so there is no overflow
// guard. Pops are only issued while count is non-zero.
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset (pointers and count)
//   push      : write push_data at the tail this edge
//   push_data : data to write
//   pop       : drop the head entry this edge
//   head      : oldest entry (undefined while count is zero)
//   count     : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module chol_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Storage is not reset; the top gates the head with its valid flag.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/chol_sqrt_sink.sv
// ---------------------------------------------------------------------------
// chol_sqrt_sink
// Collects results from a fixed-latency, clock-enabled square-root core and
// buffers them for a ready/valid consumer. Upstream may only issue an
// operand while a credit is free; a credit covers one result from issue
// until it is popped, so the buffer can never overflow.
// Ports:
//   clk         : clock for all logic
//   rst_n       : asynchronous active-low reset, released synchronously
//   clken       : clock enable shared with the square-root core
//   issue_valid : upstream presents an operand to the core this cycle
//   issue_ready : a credit is free; upstream may issue
//   core_dout   : square-root core result bus
//   out_valid   : a buffered result is available
//   out_ready   : downstream accepts the result
//   out_data    : oldest result, zero-extended to CHOL_OUT_W bits
//   occupancy   : results in flight plus results buffered
// ---------------------------------------------------------------------------
module chol_sqrt_sink
    import chol_pkg::*;
#(
    parameter int unsigned LATENCY = CHOL_SQRT_LATENCY,
    parameter int unsigned DEPTH   = CHOL_FIFO_DEPTH,
    parameter int unsigned DW      = CHOL_SQRT_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clken,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [DW-1:0]         core_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHOL_OUT_W-1:0] out_data,
    output logic [CHOL_OCC_W-1:0] occupancy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CHOL_OCC_W-1:0] DEPTH_OCC = CHOL_OCC_W'(DEPTH);

    // -----------------------------------------------------------------------
    // Reset synchroniser: asserts asynchronously, releases two edges later.
    // -----------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic               accept;
    logic               push;
    logic               pop;
    logic [LATENCY-1:0] valid_sr_q;
    logic [LATENCY-1:0] valid_sr_d;
    logic [CHOL_OCC_W-1:0] occ_q;
    logic [CHOL_OCC_W-1:0] occ_d;
    logic [DW-1:0]      fifo_head;
    logic [CNT_W-1:0]   fifo_count;

    assign issue_ready = (occ_q < DEPTH_OCC);
    assign accept      = issue_valid & issue_ready & clken;
    // The last stage lines up with the core output only on enabled edges.
    assign push        = clken & valid_sr_q[LATENCY-1];
    assign out_valid   = (fifo_count != '0);
    assign pop         = out_valid & out_ready;

    // -----------------------------------------------------------------------
    // Valid shift register mirroring the core pipeline
    // -----------------------------------------------------------------------
    always_comb begin
        valid_sr_d = valid_sr_q;
        if (clken) begin
            valid_sr_d[0] = accept;
            for (int i = 1; i < LATENCY; i++) begin
                valid_sr_d[i] = valid_sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            valid_sr_q <= '0;
        end else begin
            valid_sr_q <= valid_sr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Credit counter: a push only moves a result from in-flight to buffered,
    // so only accepts and pops change the total.
    // -----------------------------------------------------------------------
    always_comb begin
        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + CHOL_OCC_W'(1);
            2'b01:   occ_d = occ_q - CHOL_OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

    // -----------------------------------------------------------------------
    // Result buffer
    // -----------------------------------------------------------------------
    chol_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .push      (push),
        .push_data (core_dout),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Gate with out_valid so unreset storage never leaks a stale value.
    assign out_data = out_valid ? CHOL_OUT_W'(fifo_head) : '0;

endmodule

// File: tb/tb_chol_sqrt_sink.sv
// ---------------------------------------------------------------------------
// tb_chol_sqrt_sink
// Directed bench for chol_sqrt_sink. A behavioural square-root core stand-in
// returns each operand unchanged after 14 clken-high edges.
// ---------------------------------------------------------------------------
module tb_chol_sqrt_sink;

    localparam int unsigned LAT = 14;

    logic        clk;
    logic        rst_n;
    logic        clken;
    logic        issue_valid;
    logic        issue_ready;
    logic [23:0] core_dout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  occupancy;

    logic [23:0] operand;
    logic [23:0] core_pipe [LAT];

    int errors;
    int checks;

    chol_sqrt_sink dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clken       (clken),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .core_dout   (core_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: identity function with LAT clken-qualified stages.
    always @(posedge clk) begin
        if (clken) begin
            core_pipe[0] <= operand;
            for (int i = 1; i < LAT; i++) begin
                core_pipe[i] <= core_pipe[i-1];
            end
        end
    end
    assign core_dout = core_pipe[LAT-1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        clken       = 1'b1;
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        operand     = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready: got %0b want 1", issue_ready); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid: got %0b want 0", out_valid); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL post_rst_issue_ready: got %0b want 1", issue_ready); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL post_rst_occupancy: got %0d want 0", occupancy); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL post_rst_out_data: got %h want 0", out_data); end
    endtask

    task automatic test_single;
        clken       = 1'b1;
        out_ready   = 1'b0;
        operand     = 24'h00ABCD;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL single_occ_issue: got %0d want 1", occupancy); end
        repeat (LAT - 1) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        checks++; if (out_data !== 32'h0000ABCD) begin errors++; $display("FAIL single_data: got %h want 0000abcd", out_data); end
        checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL single_occ_buf: got %0d want 1", occupancy); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %0b want 0", out_valid); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL single_pop_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_credit;
        int exp_occ;
        int got;
        clken     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            operand     = 24'h000100 + 24'(i);
            issue_valid = 1'b1;
            tick();
            exp_occ = (i + 1 < 4) ? i + 1 : 4;
            checks++; if (occupancy !== 5'(exp_occ)) begin errors++; $display("FAIL credit_occ[%0d]: got %0d want %0d", i, occupancy, exp_occ); end
            checks++; if (issue_ready !== (exp_occ < 4)) begin errors++; $display("FAIL credit_ready[%0d]: got %0b want %0b", i, issue_ready, exp_occ < 4); end
        end
        issue_valid = 1'b0;
        out_ready   = 1'b1;
        got         = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (out_valid) begin
                checks++; if (out_data !== 32'h00000100 + 32'(got)) begin errors++; $display("FAIL credit_order[%0d]: got %h want %h", got, out_data, 32'h100 + got); end
                got++;
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (got !== 4) begin errors++; $display("FAIL credit_drain_count: got %0d want 4", got); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL credit_drain_occ: got %0d want 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL credit_drain_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_clken;
        int highs;
        int clocks;
        out_ready   = 1'b0;
        operand     = 24'h002222;
        clken       = 1'b0;
        issue_valid = 1'b1;
        tick();
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL clken_low_accept: got %0d want 0", occupancy); end
        clken = 1'b1;
        tick();
        issue_valid = 1'b0;
        checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL clken_accept: got %0d want 1", occupancy); end
        highs  = 0;
        clocks = 0;
        while (highs < 14 && clocks < 60) begin
            clken = (clocks % 2 == 1);
            tick();
            clocks++;
            if (clken) highs++;
            if (clocks == 14) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clken_14th_clock: got %0b want 0", out_valid); end
            end
            if (clken && highs == 13) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clken_13th_high: got %0b want 0", out_valid); end
            end
        end
        checks++; if (highs !== 14) begin errors++; $display("FAIL clken_timeout: got %0d want 14", highs); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clken_14th_high: got %0b want 1", out_valid); end
        checks++; if (out_data !== 32'h00002222) begin errors++; $display("FAIL clken_data: got %h want 00002222", out_data); end
        // Pop does not depend on clken.
        clken     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        clken     = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clken_pop_valid: got %0b want 0", out_valid); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL clken_pop_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_back_to_back;
        logic acc;
        int   nacc;
        int   nres;
        int   over;
        clken       = 1'b1;
        out_ready   = 1'b1;
        operand     = 24'd1;
        nacc        = 0;
        nres        = 0;
        over        = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            issue_valid = (cyc < 60);
            acc = issue_valid && issue_ready;
            if (out_valid) begin
                checks++; if (out_data !== 32'(nres + 1)) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", nres, out_data, nres + 1); end
                nres++;
            end
            tick();
            if (acc) begin
                nacc++;
                operand = operand + 24'd1;
            end
            if (occupancy > 5'd4) over++;
            if (cyc == 3) begin
                checks++; if (occupancy !== 5'd4) begin errors++; $display("FAIL b2b_full_occ: got %0d want 4", occupancy); end
                checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0b want 0", issue_ready); end
            end
            if (cyc == 15) begin
                checks++; if (occupancy !== 5'd3) begin errors++; $display("FAIL b2b_first_pop_occ: got %0d want 3", occupancy); end
            end
        end
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        checks++; if (over !== 0) begin errors++; $display("FAIL b2b_occ_bound: got %0d cycles above 4 want 0", over); end
        checks++; if (nacc !== 16) begin errors++; $display("FAIL b2b_accepts: got %0d want 16", nacc); end
        checks++; if (nres !== 16) begin errors++; $display("FAIL b2b_results: got %0d want 16", nres); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL b2b_end_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_reset_mid;
        int seen;
        clken       = 1'b1;
        out_ready   = 1'b0;
        operand     = 24'h000055;
        issue_valid = 1'b1;
        tick();                      // edge 0
        issue_valid = 1'b0;
        repeat (10) tick();          // edges 1..10
        operand     = 24'h000066;
        issue_valid = 1'b1;
        repeat (3) tick();           // edges 11..13
        issue_valid = 1'b0;
        tick();                      // edge 14: first result buffered
        checks++; if (occupancy !== 5'd4) begin errors++; $display("FAIL mid_occ_before: got %0d want 4", occupancy); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before: got %0b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", out_valid); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL mid_rst_occ: got %0d want 0", occupancy); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %0b want 1", issue_ready); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL mid_rst_data: got %h want 0", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_stale: got %0d valid cycles want 0", seen); end
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL mid_after_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_wide;
        clken       = 1'b1;
        out_ready   = 1'b0;
        operand     = 24'hFFFFFF;
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        repeat (LAT) tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wide_valid: got %0b want 1", out_valid); end
        checks++; if (out_data !== 32'h00FFFFFF) begin errors++; $display("FAIL wide_data: got %h want 00ffffff", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL wide_pop_occ: got %0d want 0", occupancy); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_credit();
        test_clken();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
